// File: rtl/print_pkg.sv
// Shared state encodings, default constants and width helper for the sprite print engine.
package print_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t WAIT_RESP = 2'd1;
    localparam state_t SPRITE    = 2'd2;
    localparam state_t BG_HOLD   = 2'd3;

    localparam int unsigned DEF_BG_CODE  = 1;
    localparam int unsigned DEF_ADDR_W   = 14;
    localparam int unsigned DEF_BG_ADDR  = (2 ** DEF_ADDR_W) - 1;
    localparam int unsigned DEF_V_ACTIVE = 480;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/print_cycle_counter.sv
// Loadable up/down cycle counter; terminal_o flags Limit when counting up, zero when counting down.
module print_cycle_counter #(
    parameter int unsigned Width = 4,
    parameter int unsigned Limit = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [Width-1:0] count_o,
    output logic             terminal_o
);

    localparam logic [Width-1:0] LimitV = Width'(Limit);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = up_i ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == (up_i ? LimitV : '0));

endmodule

// File: rtl/sprite_print_engine.sv
// Per-pixel print controller: coordinate lookup handshake, then background fetch or sprite line.
module sprite_print_engine
    import print_pkg::*;
#(
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BG_CODE  = DEF_BG_CODE,
    parameter int unsigned BG_ADDR  = (2 ** ADDR_W) - 1,
    parameter int unsigned BG_WAIT  = 2,
    parameter int unsigned SPRITE_W = 20,
    parameter int unsigned TIMEOUT  = 8,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             active_area,
    input  logic [X_W-1:0]                   pixel_x,
    input  logic [Y_W-1:0]                   pixel_y,
    input  logic [DATA_W-1:0]                data_reg,
    input  logic                             data_valid,
    output logic                             check_req,
    output logic [X_W+Y_W-1:0]               check_value,
    output logic                             mem_rd,
    output logic [ADDR_W-1:0]                memory_address,
    output logic [DATA_W-1:0]                sprite_datas,
    output logic                             sprite_on,
    output logic [cnt_width(SPRITE_W)-1:0]   sprite_col,
    output logic                             printing_screen,
    output logic                             timeout_err
);

    localparam int unsigned COL_W  = cnt_width(SPRITE_W);
    localparam int unsigned WAIT_N = (TIMEOUT > BG_WAIT) ? TIMEOUT : BG_WAIT;
    localparam int unsigned WAIT_W = cnt_width(WAIT_N);

    localparam logic [DATA_W-1:0] BgCodeV  = DATA_W'(BG_CODE);
    localparam logic [ADDR_W-1:0] BgAddrV  = ADDR_W'(BG_ADDR);
    localparam logic [Y_W:0]      VActiveV = (Y_W + 1)'(V_ACTIVE);
    localparam logic [WAIT_W-1:0] TmoLoad  = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] BgLoad   = WAIT_W'(BG_WAIT - 1);

    state_t              state_q, state_d;
    logic                check_req_q, check_req_d;
    logic [X_W+Y_W-1:0]  check_value_q, check_value_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   sprite_datas_q, sprite_datas_d;
    logic                sprite_on_q, sprite_on_d;
    logic                timeout_err_q, timeout_err_d;
    logic                printing_q;

    logic                col_load, col_en, col_term;
    logic [COL_W-1:0]    col_cnt;
    logic                wait_load, wait_en, wait_term;
    logic [WAIT_W-1:0]   wait_load_val, wait_cnt;
    logic                unused_wait_cnt;

    print_cycle_counter #(
        .Width (COL_W),
        .Limit (SPRITE_W - 1)
    ) u_col_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (col_load),
        .load_val_i ('0),
        .en_i       (col_en),
        .up_i       (1'b1),
        .count_o    (col_cnt),
        .terminal_o (col_term)
    );

    // Shared between the response timeout and the background hold; the state selects the use.
    print_cycle_counter #(
        .Width (WAIT_W),
        .Limit (0)
    ) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wait_load),
        .load_val_i (wait_load_val),
        .en_i       (wait_en),
        .up_i       (1'b0),
        .count_o    (wait_cnt),
        .terminal_o (wait_term)
    );

    assign unused_wait_cnt = ^wait_cnt;

    always_comb begin
        state_d        = state_q;
        check_req_d    = 1'b0;
        mem_rd_d       = 1'b0;
        timeout_err_d  = 1'b0;
        check_value_d  = check_value_q;
        mem_addr_d     = mem_addr_q;
        sprite_datas_d = sprite_datas_q;
        sprite_on_d    = sprite_on_q;
        col_load       = 1'b0;
        col_en         = 1'b0;
        wait_load      = 1'b0;
        wait_load_val  = TmoLoad;
        wait_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (active_area) begin
                    check_value_d = {pixel_x, pixel_y};
                    check_req_d   = 1'b1;
                    wait_load     = 1'b1;
                    wait_load_val = TmoLoad;
                    state_d       = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response on the expiry cycle still counts, so data_valid is tested first.
                if (data_valid && (data_reg != BgCodeV)) begin
                    sprite_datas_d = data_reg;
                    sprite_on_d    = 1'b1;
                    col_load       = 1'b1;
                    state_d        = SPRITE;
                end else if (data_valid || wait_term) begin
                    timeout_err_d = !data_valid;
                    mem_addr_d    = BgAddrV;
                    mem_rd_d      = 1'b1;
                    wait_load     = 1'b1;
                    wait_load_val = BgLoad;
                    state_d       = BG_HOLD;
                end else begin
                    wait_en = 1'b1;
                end
            end
            SPRITE: begin
                if (!active_area || col_term) begin
                    sprite_on_d = 1'b0;
                    col_load    = 1'b1;
                    state_d     = IDLE;
                end else begin
                    col_en = 1'b1;
                end
            end
            BG_HOLD: begin
                if (wait_term) begin
                    state_d = IDLE;
                end else begin
                    wait_en = 1'b1;
                end
            end
            default: begin
                sprite_on_d = 1'b0;
                col_load    = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            check_req_q    <= 1'b0;
            check_value_q  <= '0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= '0;
            sprite_datas_q <= '0;
            sprite_on_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            printing_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            check_req_q    <= check_req_d;
            check_value_q  <= check_value_d;
            mem_rd_q       <= mem_rd_d;
            mem_addr_q     <= mem_addr_d;
            sprite_datas_q <= sprite_datas_d;
            sprite_on_q    <= sprite_on_d;
            timeout_err_q  <= timeout_err_d;
            printing_q     <= ({1'b0, pixel_y} < VActiveV);
        end
    end

    assign check_req       = check_req_q;
    assign check_value     = check_value_q;
    assign mem_rd          = mem_rd_q;
    assign memory_address  = mem_addr_q;
    assign sprite_datas    = sprite_datas_q;
    assign sprite_on       = sprite_on_q;
    assign sprite_col      = col_cnt;
    assign printing_screen = printing_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_sprite_print_engine.sv
// Self-checking bench for sprite_print_engine: directed corner cases plus randomized pixel transactions.
module tb_sprite_print_engine;

    localparam int unsigned BG_WAIT  = 2;
    localparam int unsigned SPRITE_W = 20;
    localparam int unsigned TIMEOUT  = 8;
    localparam int unsigned V_ACTIVE = 480;
    localparam logic [31:0] BG_ADDR  = 32'h3FFF;

    logic        clk;
    logic        reset;
    logic        active_area;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [31:0] data_reg;
    logic        data_valid;
    logic        check_req;
    logic [19:0] check_value;
    logic        mem_rd;
    logic [13:0] memory_address;
    logic [31:0] sprite_datas;
    logic        sprite_on;
    logic [4:0]  sprite_col;
    logic        printing_screen;
    logic        timeout_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_sd  = 32'h0;
    logic [31:0] exp_cv  = 32'h0;

    sprite_print_engine dut (
        .clk             (clk),
        .reset           (reset),
        .active_area     (active_area),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .data_reg        (data_reg),
        .data_valid      (data_valid),
        .check_req       (check_req),
        .check_value     (check_value),
        .mem_rd          (mem_rd),
        .memory_address  (memory_address),
        .sprite_datas    (sprite_datas),
        .sprite_on       (sprite_on),
        .sprite_col      (sprite_col),
        .printing_screen (printing_screen),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit later; printing_screen follows pixel_y at the edge.
    task automatic tick();
        logic [9:0] y_e;
        logic       r_e;
        y_e = pixel_y;
        r_e = reset;
        @(posedge clk);
        #1;
        if (r_e && reset) chk("printing_screen", printing_screen, (y_e < V_ACTIVE) ? 1 : 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_check_req"}, check_req, 0);
        chk({tag, "_check_value"}, check_value, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, memory_address, 0);
        chk({tag, "_sprite_datas"}, sprite_datas, 0);
        chk({tag, "_sprite_on"}, sprite_on, 0);
        chk({tag, "_sprite_col"}, sprite_col, 0);
        chk({tag, "_printing"}, printing_screen, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // One pixel transaction from IDLE. d = idle response cycles before data_valid (>= TIMEOUT means
    // no response). abort_kind: 0 none, 1 drop active_area at abort_col, 2 reset at abort_col.
    task automatic run_pixel(input int unsigned x, input int unsigned y, input int unsigned d,
                             input logic [31:0] resp, input int abort_kind,
                             input int unsigned abort_col);
        bit timed_out;
        bit is_bg;
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        active_area = 1'b1;
        data_valid  = 1'b0;
        tick();
        exp_cv = (x % 1024) * 1024 + (y % 1024);
        chk("start_check_req", check_req, 1);
        chk("start_check_value", check_value, exp_cv);
        chk("start_sprite_on", sprite_on, 0);
        chk("start_mem_rd", mem_rd, 0);
        pixel_x   = 10'($urandom);
        timed_out = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            data_valid = (k == d + 1);
            data_reg   = data_valid ? resp : $urandom;
            tick();
            if (data_valid) break;
            if (k == TIMEOUT) begin
                timed_out = 1;
                break;
            end
            chk("wait_check_req", check_req, 0);
            chk("wait_mem_rd", mem_rd, 0);
            chk("wait_timeout_err", timeout_err, 0);
            chk("wait_sprite_on", sprite_on, 0);
        end
        data_valid = 1'b0;
        data_reg   = $urandom;
        is_bg      = timed_out || (resp == 32'h1);
        chk("resp_timeout_err", timeout_err, timed_out ? 1 : 0);
        chk("resp_check_req", check_req, 0);
        chk("resp_check_value_held", check_value, exp_cv);
        if (is_bg) begin
            chk("bg_mem_rd", mem_rd, 1);
            chk("bg_mem_addr", memory_address, BG_ADDR);
            chk("bg_sprite_on", sprite_on, 0);
            chk("bg_sprite_datas_held", sprite_datas, exp_sd);
            for (int i = 0; i < BG_WAIT; i++) begin
                tick();
                chk("hold_mem_rd", mem_rd, 0);
                chk("hold_timeout_err", timeout_err, 0);
                chk("hold_check_req", check_req, 0);
                chk("hold_mem_addr", memory_address, BG_ADDR);
            end
            return;
        end
        exp_sd = resp;
        chk("spr_sprite_on", sprite_on, 1);
        chk("spr_sprite_col", sprite_col, 0);
        chk("spr_sprite_datas", sprite_datas, exp_sd);
        chk("spr_mem_rd", mem_rd, 0);
        for (int c = 1; c <= SPRITE_W; c++) begin
            if (abort_kind == 1 && c - 1 == abort_col) begin
                active_area = 1'b0;
                tick();
                chk("drop_sprite_on", sprite_on, 0);
                chk("drop_sprite_col", sprite_col, 0);
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("drop_check_req", check_req, 0);
                    chk("drop_sprite_on_low", sprite_on, 0);
                end
                return;
            end
            if (abort_kind == 2 && c - 1 == abort_col) begin
                #1 reset = 1'b0;
                #1 chk_all_zero("rst_mid");
                exp_sd = 32'h0;
                #1 reset = 1'b1;
                active_area = 1'b0;
                tick();
                chk("rst_after_check_req", check_req, 0);
                return;
            end
            tick();
            if (c < SPRITE_W) begin
                chk("spr_col_step", sprite_col, c);
                chk("spr_on_run", sprite_on, 1);
            end else begin
                chk("spr_end_on", sprite_on, 0);
                chk("spr_end_col", sprite_col, 0);
                chk("spr_end_check_req", check_req, 0);
                chk("spr_end_datas_held", sprite_datas, exp_sd);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        reset       = 1'b0;
        active_area = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        data_reg    = '0;
        data_valid  = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();
        chk("idle_no_req", check_req, 0);

        pixel_y = 10'd479;
        tick();
        chk("ps_479", printing_screen, 1);
        pixel_y = 10'd480;
        tick();
        chk("ps_480", printing_screen, 0);
        pixel_y = 10'd524;
        tick();
        chk("ps_524", printing_screen, 0);

        run_pixel(100, 50, 0, 32'h00000001, 0, 0);
        chk("dir_check_value", check_value, 32'h19032);
        run_pixel(100, 51, 0, 32'hA5A50010, 0, 0);
        run_pixel(3, 4, TIMEOUT, 32'hDEADBEEF, 0, 0);
        run_pixel(5, 6, TIMEOUT - 1, 32'h12345678, 0, 0);
        run_pixel(7, 8, 2, 32'h0BADF00D, 1, 7);
        run_pixel(9, 10, 1, 32'hCAFE0002, 2, 5);
        run_pixel(11, 12, 3, 32'h00000001, 0, 0);

        for (int n = 0; n < 30; n++) begin
            rd = ($urandom_range(0, 9) < 4) ? 32'h1 : $urandom;
            if (rd == 32'h1 && $urandom_range(0, 1) == 1) rd = 32'h2;
            run_pixel($urandom_range(0, 799), $urandom_range(0, 524), $urandom_range(0, TIMEOUT + 1),
                      rd, ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, SPRITE_W - 1));
        end
        active_area = 1'b0;
        tick();
        tick();
        chk("final_idle", check_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_print_engine.md
Name: sprite_print_engine

Overview:
Next-generation pixel print controller for the VGA sprite pipeline. For each active-area pixel it sends the current coordinate to the register bank and waits for a validated response. It then either fetches the background colour from memory, or drives a sprite descriptor out for a parametrised number of pixel columns. It replaces fixed-latency lookup with a request/valid handshake, adds an internal column counter and configurable background wait, reports response timeouts, and runs on a single clock.

Parameters:
X_W, 10, pixel_x width
Y_W, 10, pixel_y width
ADDR_W, 14, memory address width
DATA_W, 32, register-bank data / sprite descriptor width
BG_CODE, 1, data_reg value meaning "pixel is background"
BG_ADDR, 2**ADDR_W-1, memory address holding the background colour
BG_WAIT, 2, cycles held in background state (>=1)
SPRITE_W, 20, pixel columns per sprite line (>=1)
TIMEOUT, 8, max cycles waiting for data_valid (>=1)
V_ACTIVE, 480, visible lines per frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
active_area  in  1  monitor in visible region
pixel_x  in  X_W  current x coordinate
pixel_y  in  Y_W  current y coordinate
data_reg  in  DATA_W  register-bank lookup result
data_valid  in  1  data_reg valid for the outstanding request
check_req  out  1  one-cycle pulse: check_value is a new lookup
check_value  out  X_W+Y_W  {x,y}; x in [X_W+Y_W-1:Y_W], y in [Y_W-1:0]
mem_rd  out  1  one-cycle pulse: read memory_address
memory_address  out  ADDR_W  memory address to read
sprite_datas  out  DATA_W  latched sprite descriptor
sprite_on  out  1  sprite line being printed
sprite_col  out  max(1,$clog2(SPRITE_W))  current column within sprite
printing_screen  out  1  pixel_y < V_ACTIVE
timeout_err  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset is asynchronous and active-low, clock is clk. Every output is registered on posedge clk.
- Reset values: all outputs 0; state IDLE; counters 0.
- FSM states: IDLE, WAIT_RESP, SPRITE, BG_HOLD.
- IDLE:
  - If active_area=1: latch {pixel_x,pixel_y} into check_value, pulse check_req, load timeout counter, go to WAIT_RESP.
  - Otherwise stay in IDLE.
  - data_valid is ignored in IDLE.
- WAIT_RESP, data_valid=1 and data_reg==BG_CODE: memory_address<=BG_ADDR, pulse mem_rd, load wait counter with BG_WAIT-1, go to BG_HOLD.
- WAIT_RESP, data_valid=1 and data_reg!=BG_CODE: sprite_datas<=data_reg, sprite_on<=1, sprite_col<=0, go to SPRITE.
- WAIT_RESP, no data_valid for TIMEOUT cycles: pulse timeout_err, then take the background path (mem_rd, BG_ADDR, BG_HOLD).
- WAIT_RESP, data_valid on the same cycle the timeout expires: data_valid wins and no error is raised.
- SPRITE:
  - sprite_col increments by 1 each cycle.
  - When sprite_col==SPRITE_W-1: sprite_on<=0, sprite_col<=0, go to IDLE.
  - If active_area drops: abort, so sprite_on<=0 on the next edge and the FSM returns to IDLE.
  - sprite_datas holds its value until the next sprite is accepted.
- BG_HOLD: wait counter decrements each cycle; at 0 go to IDLE. memory_address holds BG_ADDR.
- Back-to-back operation: from IDLE with active_area continuously high, the next check_req occurs the cycle after returning to IDLE.
- Latency: check_req rises 1 cycle after active_area is sampled high in IDLE; sprite_on rises 1 cycle after the accepted data_valid.
- printing_screen is registered every cycle, independent of the FSM.
- Reset asserted mid-operation returns the block to IDLE immediately and clears all outputs. No partial pulse survives.
- Unused/default state encodings recover to IDLE.

Decomposition:
- Package print_pkg holds:
  - state enum (IDLE, WAIT_RESP, SPRITE, BG_HOLD)
  - default constants BG_CODE, BG_ADDR, V_ACTIVE
  - helper function for sprite_col width
- Sub-module print_cycle_counter: loadable counter with up/down select and a terminal flag. Instantiated for sprite columns and shared (time-multiplexed by state) for the timeout and BG wait counts.

Test Plan:
- Reset mid-SPRITE (sprite_col=5): assert reset=0 -> all outputs 0 and state IDLE immediately; after release, first check_req follows active_area=1.
- active_area=1, pixel_x=100, pixel_y=50; data_valid with data_reg=32'h00000001 next cycle -> check_value=20'h19032 with a 1-cycle check_req; then mem_rd pulse, memory_address=16383; back in IDLE after BG_WAIT=2 cycles.
- data_valid with data_reg=32'hA5A50010 -> sprite_datas=32'hA5A50010, sprite_on high for exactly 20 cycles, sprite_col steps 0..19, then IDLE.
- No data_valid for 8 cycles -> timeout_err pulses once, background path taken; data_valid arriving on cycle 8 instead -> no timeout_err.
- active_area drops at sprite_col=7 -> sprite_on low next edge, IDLE, no check_req until active_area returns.
- pixel_y=479 -> printing_screen=1; pixel_y=480 -> printing_screen=0 one cycle later; pixel_y=524 -> 0.
